// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and a sticky fault flag for misaligned redirects and fetches outside the ROM window.
module fetch_stage #(
  parameter int unsigned               DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned               ROM_BYTES    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f,
  input  logic                  flush_d,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  output logic [DATA_WIDTH-1:0] pc_f,
  input  logic [DATA_WIDTH-1:0] instr_f,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic                  fetch_fault
);

  localparam logic [DATA_WIDTH-1:0] Nop      = DATA_WIDTH'(32'h00000013);
  localparam logic [DATA_WIDTH-1:0] Four     = DATA_WIDTH'(4);
  // Window bounds carried one bit wider so RESET_VECTOR + ROM_BYTES cannot wrap.
  localparam logic [DATA_WIDTH:0]   RomLo    = {1'b0, RESET_VECTOR};
  localparam logic [DATA_WIDTH:0]   RomSize  = (DATA_WIDTH + 1)'(ROM_BYTES);
  localparam logic [DATA_WIDTH:0]   RomHi    = RomLo + RomSize - (DATA_WIDTH + 1)'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_next;
  logic [DATA_WIDTH-1:0] instr_q, instr_next;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_next;
  logic [DATA_WIDTH-1:0] p4_q, p4_next;
  logic                  valid_q, valid_next;
  logic                  fault_q, fault_next;

  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH:0]   pc_ext;
  logic                  capture;
  logic                  out_of_window;
  logic                  misaligned;

  assign pc_f          = pc_q;
  assign pc_plus4_f    = pc_q + Four;
  assign pc_ext        = {1'b0, pc_q};
  assign capture       = !flush_d && !stall_f;
  assign out_of_window = (pc_ext < RomLo) || (pc_ext > RomHi);
  assign misaligned    = pc_src_e && (pc_target_e[1:0] != 2'b00);

  // Redirect wins over stall so a taken branch is never dropped.
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e) begin
      pc_next = {pc_target_e[DATA_WIDTH-1:2], 2'b00};
    end else if (stall_f) begin
      pc_next = pc_q;
    end
  end

  always_comb begin
    instr_next = instr_q;
    pcd_next   = pcd_q;
    p4_next    = p4_q;
    valid_next = valid_q;
    if (flush_d) begin
      instr_next = Nop;
      pcd_next   = '0;
      p4_next    = '0;
      valid_next = 1'b0;
    end else if (!stall_f) begin
      instr_next = instr_f;
      pcd_next   = pc_q;
      p4_next    = pc_plus4_f;
      valid_next = 1'b1;
    end
  end

  always_comb begin
    fault_next = fault_q;
    if (misaligned || (capture && out_of_window)) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= Nop;
      pcd_q   <= '0;
      p4_q    <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      instr_q <= instr_next;
      pcd_q   <= pcd_next;
      p4_q    <= p4_next;
      valid_q <= valid_next;
      fault_q <= fault_next;
    end
  end

  assign instr_d     = instr_q;
  assign pc_d        = pcd_q;
  assign pc_plus4_d  = p4_q;
  assign valid_d     = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and
// randomized traffic checked against a behavioural pipeline model.
module tb_fetch_stage;

  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam int unsigned ROMB  = 4096;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(RV),
    .ROM_BYTES   (ROMB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_f    (stall_f),
    .flush_d    (flush_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .pc_f       (pc_f),
    .instr_f    (instr_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic ROM contents: a distinct word for every address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ a[15:0] ^ 16'h1234};
  endfunction

  assign instr_f = rom(pc_f);

  // Behavioural model: the architectural state a fetch stage should hold.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic        m_valid, m_fault;

  function automatic void model_reset();
    m_pc = RV; m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_fault = 0;
  endfunction

  function automatic void model_step(input logic s, input logic f, input logic r,
                                     input logic [31:0] t);
    longint unsigned pc_l;
    bit in_win;
    pc_l   = longint'(m_pc);
    in_win = (pc_l >= longint'(RV)) && (pc_l <= longint'(RV) + ROMB - 4);
    if ((r && (t % 4 != 0)) || (!f && !s && !in_win)) m_fault = 1;
    if (f) begin
      m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = rom(m_pc); m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_valid = 1;
    end
    if (r)       m_pc = t - (t % 4);
    else if (!s) m_pc = m_pc + 32'd4;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".pc_f"},        pc_f,        m_pc);
    check({tag, ".instr_d"},     instr_d,     m_instr);
    check({tag, ".pc_d"},        pc_d,        m_pcd);
    check({tag, ".pc_plus4_d"},  pc_plus4_d,  m_p4);
    check({tag, ".valid_d"},     32'(valid_d),     32'(m_valid));
    check({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(m_fault));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc_f"},        pc_f,        RV);
    check({tag, ".instr_d"},     instr_d,     NOP);
    check({tag, ".pc_d"},        pc_d,        32'h0);
    check({tag, ".pc_plus4_d"},  pc_plus4_d,  32'h0);
    check({tag, ".valid_d"},     32'(valid_d),     32'h0);
    check({tag, ".fetch_fault"}, 32'(fetch_fault), 32'h0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic s, input logic f, input logic r, input logic [31:0] t,
                       input string tag);
    stall_f = s; flush_d = f; pc_src_e = r; pc_target_e = t;
    model_step(s, f, r, t);
    @(posedge clk);
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_f = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] e_pcf;
    logic [31:0] e_pcd;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0, 0, 0, 32'h0,        RV + 32'h004, RV + 32'h000, 1, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,        RV + 32'h008, RV + 32'h004, 1, 0};
    vecs[2]  = '{1, 0, 0, 32'h0,        RV + 32'h008, RV + 32'h004, 1, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,        RV + 32'h008, RV + 32'h004, 1, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,        RV + 32'h00C, RV + 32'h008, 1, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,        RV + 32'h010, RV + 32'h00C, 1, 0};
    vecs[6]  = '{1, 0, 1, RV + 32'h100, RV + 32'h100, RV + 32'h00C, 1, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,        RV + 32'h104, RV + 32'h100, 1, 0};
    vecs[8]  = '{1, 1, 0, 32'h0,        RV + 32'h104, 32'h0,        0, 0};
    vecs[9]  = '{0, 0, 0, 32'h0,        RV + 32'h108, RV + 32'h104, 1, 0};
    vecs[10] = '{0, 0, 1, RV + 32'h102, RV + 32'h100, RV + 32'h108, 1, 1};
    vecs[11] = '{0, 0, 0, 32'h0,        RV + 32'h104, RV + 32'h100, 1, 1};
    vecs[12] = '{0, 0, 0, 32'h0,        RV + 32'h108, RV + 32'h104, 1, 1};
  end

  initial begin
    logic [31:0] tgt;
    logic        s, f, r;
    int          sel;

    rst_n = 1'b0; stall_f = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Directed table with independently written expectations.
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].stall, vecs[i].flush, vecs[i].src, vecs[i].tgt, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.exp_pc_f", i), pc_f, vecs[i].e_pcf);
      check($sformatf("vec%0d.exp_pc_d", i), pc_d, vecs[i].e_pcd);
      check($sformatf("vec%0d.exp_valid", i), 32'(valid_d), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.exp_fault", i), 32'(fetch_fault), 32'(vecs[i].e_fault));
      check($sformatf("vec%0d.exp_instr", i), instr_d,
            vecs[i].e_valid ? rom(vecs[i].e_pcd) : NOP);
      check($sformatf("vec%0d.exp_p4", i), pc_plus4_d,
            vecs[i].e_valid ? vecs[i].e_pcd + 32'd4 : 32'h0);
    end

    // Reset clears the sticky fault; then fetch past the end of the window.
    do_reset();
    cycle(0, 0, 1, RV + 32'h1000, "oob_redirect");
    check("oob_redirect.pc_f", pc_f, RV + 32'h1000);
    check("oob_redirect.fault", 32'(fetch_fault), 32'h0);
    cycle(0, 0, 0, 32'h0, "oob_capture");
    check("oob_capture.fault", 32'(fetch_fault), 32'h1);
    check("oob_capture.pc_d", pc_d, RV + 32'h1000);
    cycle(1, 0, 0, 32'h0, "oob_hold");
    check("oob_hold.fault", 32'(fetch_fault), 32'h1);

    // Last word of the window captures cleanly; the +4 step beyond it still advances.
    do_reset();
    cycle(0, 0, 1, RV + ROMB - 4, "edge_redirect");
    cycle(0, 0, 0, 32'h0, "edge_capture");
    check("edge_capture.fault", 32'(fetch_fault), 32'h0);
    check("edge_capture.pc_f", pc_f, RV + ROMB);

    // PC wraps modulo 2^32.
    cycle(0, 0, 1, 32'hFFFFFFFC, "wrap_redirect");
    cycle(0, 0, 0, 32'h0, "wrap_step");
    check("wrap_step.pc_f", pc_f, 32'h0);
    check("wrap_step.pc_plus4_d", pc_plus4_d, 32'h0);

    // Asynchronous reset asserted between edges with a redirect pending.
    stall_f = 1; flush_d = 0; pc_src_e = 1; pc_target_e = RV + 32'h200;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    stall_f = 0; pc_src_e = 0; pc_target_e = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 32'h0, "post_rst");
    check("post_rst.pc_f", pc_f, RV + 32'h4);
    check("post_rst.instr_d", instr_d, rom(RV));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        s   = ($urandom_range(0, 3) == 0);
        f   = ($urandom_range(0, 5) == 0);
        r   = ($urandom_range(0, 6) == 0);
        sel = $urandom_range(0, 9);
        if (sel < 6)       tgt = RV + 4 * $urandom_range(0, ROMB / 4 - 1);
        else if (sel == 6) tgt = RV + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        else if (sel == 7) tgt = RV + ROMB + 4 * $urandom_range(0, 15);
        else if (sel == 8) tgt = 32'hFFFFFFFC;
        else               tgt = $urandom;
        cycle(s, f, r, tgt, $sformatf("rnd%0d", k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
